ceiling_top: RTL and testbench
==============================

Name: ceiling_top

Overview:
- Top-level FPGA block for the ceiling lighting controller.
- Bridges an ARM GPMC bus (multiplexed address/data, asynchronous mode) to a small register file.
- Register file drives four status LEDs and two WS2812-style serial LED strings (led_sdi).
- Entire design runs on a single 100 MHz clock domain; GPMC control pins are oversampled.

Parameters:
- T0H, 40, clk_100 cycles a '0' bit stays high
- T1H, 80, clk_100 cycles a '1' bit stays high
- TBIT, 125, total clk_100 cycles per serial bit (1.25 us)
- ID_VALUE, 16'hCE11, read-only identification word

Ports:
- clk_100  input  1  system clock, 100 MHz, sole clock of the block
- reset  input  1  synchronous, active-high reset
- led  output  4  board status LEDs
- gpmc_ad  inout  16  multiplexed GPMC address/data
- gpmc_advn  input  1  address valid, active-low
- gpmc_csn1  input  1  chip select, active-low
- gpmc_wein  input  1  write enable, active-low
- gpmc_oen  input  1  output enable, active-low
- led_sdi  output  2  serial data to LED string 0/1

Behaviour:
- Interface: one clock (clk_100); reset is synchronous and active-high; all state changes on posedge clk_100.
- Reset values: led=0, led_sdi=0, both channels idle, overflow flags 0, latched address 0, gpmc_ad high-Z.
- Synchronisers: csn1, advn, wein, oen and ad[15:0] each pass through a 2-flop synchroniser before use.
- Minimum GPMC timing: every bus phase (address, data, CS high) lasts at least 4 clk_100 cycles.
- Address capture: every cycle with synced csn=0 and advn=0, addr <= synced ad.
- Write data capture: every cycle with synced csn=0, advn=1 and wein=0:
  - wdata <= synced ad
  - wr_pend <= 1
- Write commit: on a synced csn 0->1 edge with wr_pend=1, perform one write to addr, then clear wr_pend. Exactly one write per CS assertion.
- Register map (16-bit word addresses):
  - 0x0000 ID: read-only, returns ID_VALUE.
  - 0x0001 LED: rw; bits[3:0] drive led, upper bits read 0.
  - 0x0002 STATUS: read; bit0 = ch0 busy, bit1 = ch1 busy, bit2 = ch0 overflow, bit3 = ch1 overflow. Writing 1 to bit2/bit3 clears the matching flag.
  - 0x1000 / 0x1001 CH0 / CH1 DATA: write-only; reads 0.
  - Any other address: writes ignored, reads 0.
- Channel operation (each channel independent):
  - Idle + DATA write: load 16-bit shift register, busy=1, start on the next cycle.
  - Bits are sent MSB first. For each bit, led_sdi is high for T1H (bit=1) or T0H (bit=0) cycles, then low for the remainder of TBIT.
  - After 16 bits: busy=0, led_sdi stays low.
  - DATA write while busy: write dropped, overflow flag set, transmission continues unaffected.
  - Simultaneous completion and write in the same cycle: write dropped.
- Reset mid-transmission: output forced low immediately, channel returns to idle.

Optional Feature:
- Macro GPMC_READBACK_EN.
- Defined: while raw csn1=0, oen=0 and advn=1 (combinational output enable), gpmc_ad drives rd_data. rd_data is registered from a decode of the latched addr, updated every cycle.
- Undefined: gpmc_ad is never driven (always high-Z); the bus is write-only.

Test Plan:
- Reset: assert reset 10 cycles -> led=0, led_sdi=2'b00, gpmc_ad high-Z.
- Write 0x0001=0x0005 (address phase, data phase, CS high; each phase 4+ cycles) -> led=4'b0101 within 6 cycles of CS rising.
- Write 0x1000=0xABCD -> led_sdi[0] emits 16 bits MSB first, pattern 1010101111001101. Measure high time: 80 cycles for '1', 40 for '0'; every bit period 125 cycles; led_sdi[1] stays 0.
- Four back-to-back writes of 0xABCD to 0x1000 -> only the first is transmitted (2000 cycles total); STATUS bit2=1; writing STATUS=0x0004 clears it.
- With GPMC_READBACK_EN: read 0x0000 -> 0xCE11; read 0x0001 after the LED write -> 0x0005. Without the macro -> bus stays high-Z.
- Reset asserted halfway through a CH1 transmission -> led_sdi[1]=0 on the next cycle, STATUS bit1=0.

Source files
------------

// File: rtl/ceiling_top.sv
// ceiling_top: GPMC register bridge driving four status LEDs and two WS2812-style strings.
// Define GPMC_READBACK_EN to let the GPMC bus read registers back; otherwise gpmc_ad is never driven.
module ceiling_top #(
    parameter int          T0H      = 40,
    parameter int          T1H      = 80,
    parameter int          TBIT     = 125,
    parameter logic [15:0] ID_VALUE = 16'hCE11
) (
    input  logic        clk_100,
    input  logic        reset,
    output logic [3:0]  led,
    inout  wire  [15:0] gpmc_ad,
    input  logic        gpmc_advn,
    input  logic        gpmc_csn1,
    input  logic        gpmc_wein,
    input  logic        gpmc_oen,
    output logic [1:0]  led_sdi
);
    logic [1:0]  csn_q, advn_q, wein_q, oen_q;
    logic [15:0] ad_q0, ad_q1;
    logic        csn_s, advn_s, wein_s, oen_s;
    logic        csn_d, wr_pend, commit, st_wr;
    logic [15:0] addr, wdata, rd_data;
    logic [1:0]  busy, ovf, ch_wr;
    // control pins idle high so no false CS edge is seen out of reset
    always_ff @(posedge clk_100) begin
        if (reset) begin
            csn_q  <= 2'b11;
            advn_q <= 2'b11;
            wein_q <= 2'b11;
            oen_q  <= 2'b11;
            ad_q0  <= '0;
            ad_q1  <= '0;
        end else begin
            csn_q  <= {csn_q[0], gpmc_csn1};
            advn_q <= {advn_q[0], gpmc_advn};
            wein_q <= {wein_q[0], gpmc_wein};
            oen_q  <= {oen_q[0], gpmc_oen};
            ad_q0  <= gpmc_ad;
            ad_q1  <= ad_q0;
        end
    end
    assign csn_s  = csn_q[1];
    assign advn_s = advn_q[1];
    assign wein_s = wein_q[1];
    assign oen_s  = oen_q[1];
    assign commit = csn_s & ~csn_d & wr_pend;
    assign st_wr  = commit && addr == 16'h0002;
    always_ff @(posedge clk_100) begin
        if (reset) begin
            csn_d   <= 1'b1;
            addr    <= '0;
            wdata   <= '0;
            wr_pend <= 1'b0;
            led     <= '0;
        end else begin
            csn_d <= csn_s;
            if (!csn_s && !advn_s)
                addr <= ad_q1;
            if (!csn_s && advn_s && !wein_s) begin
                wdata   <= ad_q1;
                wr_pend <= 1'b1;
            end else if (commit)
                wr_pend <= 1'b0;
            if (commit && addr == 16'h0001)
                led <= wdata[3:0];
        end
    end
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [15:0] sh;
        logic [6:0]  cnt;
        logic [3:0]  nb;
        logic        bsy, ov, sdi;
        assign ch_wr[c]   = commit && addr == (16'h1000 | 16'(c));
        assign busy[c]    = bsy;
        assign ovf[c]     = ov;
        assign led_sdi[c] = sdi;
        always_ff @(posedge clk_100) begin
            if (reset) begin
                sh  <= '0;
                cnt <= '0;
                nb  <= '0;
                bsy <= 1'b0;
                ov  <= 1'b0;
                sdi <= 1'b0;
            end else begin
                sdi <= bsy && cnt < 7'(sh[15] ? T1H : T0H);
                if (ch_wr[c] && bsy)
                    ov <= 1'b1;
                else if (st_wr && wdata[2+c])
                    ov <= 1'b0;
                if (!bsy) begin
                    if (ch_wr[c]) begin
                        sh  <= wdata;
                        cnt <= '0;
                        nb  <= '0;
                        bsy <= 1'b1;
                    end
                end else if (cnt == 7'(TBIT - 1)) begin
                    cnt <= '0;
                    sh  <= {sh[14:0], 1'b0};
                    nb  <= nb + 4'd1;
                    if (nb == 4'd15)
                        bsy <= 1'b0;
                end else
                    cnt <= cnt + 7'd1;
            end
        end
    end
    always_ff @(posedge clk_100) begin
        if (reset)
            rd_data <= '0;
        else
            rd_data <= addr == 16'h0000 ? ID_VALUE :
                       addr == 16'h0001 ? {12'h000, led} :
                       addr == 16'h0002 ? {12'h000, ovf, busy} : 16'h0000;
    end
    logic unused_sig;
`ifdef GPMC_READBACK_EN
    assign gpmc_ad    = (!gpmc_csn1 && !gpmc_oen && gpmc_advn) ? rd_data : 16'hzzzz;
    assign unused_sig = oen_s;
`else
    assign gpmc_ad    = 16'hzzzz;
    assign unused_sig = ^{oen_s, rd_data};
`endif
endmodule

// File: tb/tb_ceiling_top.sv
// tb_ceiling_top: random GPMC writes checked against a timing model of the serial LED protocol.
module tb_ceiling_top;
    localparam int T0H = 40, T1H = 80, TBIT = 125;
    localparam logic [15:0] ID = 16'hCE11;
    logic        clk_100 = 1'b0, reset = 1'b1;
    logic [3:0]  led;
    wire  [15:0] gpmc_ad;
    logic        gpmc_advn = 1'b1, gpmc_csn1 = 1'b1, gpmc_wein = 1'b1, gpmc_oen = 1'b1;
    logic [1:0]  led_sdi;
    logic [15:0] ad_drv = '0;
    logic        ad_oe = 1'b0;
    int          n_vec = 0, n_err = 0;
    logic [3:0]  led_exp = '0;

    assign gpmc_ad = ad_oe ? ad_drv : 16'hzzzz;
    always #5 clk_100 = ~clk_100;

    ceiling_top dut (
        .clk_100(clk_100), .reset(reset), .led(led), .gpmc_ad(gpmc_ad),
        .gpmc_advn(gpmc_advn), .gpmc_csn1(gpmc_csn1), .gpmc_wein(gpmc_wein),
        .gpmc_oen(gpmc_oen), .led_sdi(led_sdi)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk_100);
    endtask

    task automatic gpmc_write(logic [15:0] a, logic [15:0] d);
        @(negedge clk_100);
        gpmc_csn1 = 1'b0; gpmc_advn = 1'b0; ad_drv = a; ad_oe = 1'b1;
        cycles(5);
        gpmc_advn = 1'b1; ad_drv = d; gpmc_wein = 1'b0;
        cycles(5);
        gpmc_wein = 1'b1; gpmc_csn1 = 1'b1; ad_oe = 1'b0;
        cycles(5);
    endtask

    task automatic gpmc_read(logic [15:0] a, output logic [15:0] v);
        @(negedge clk_100);
        gpmc_csn1 = 1'b0; gpmc_advn = 1'b0; ad_drv = a; ad_oe = 1'b1;
        cycles(5);
        gpmc_advn = 1'b1; ad_oe = 1'b0; gpmc_oen = 1'b0;
        cycles(6);
        v = gpmc_ad;
        gpmc_oen = 1'b1; gpmc_csn1 = 1'b1;
        cycles(5);
    endtask

    // expected waveform: per bit, high T1H/T0H then low to TBIT; silence after bit 0
    task automatic measure(int ch, logic [15:0] d);
        int t = 0, hi, lo, other = 0;
        while (!led_sdi[ch] && t < 300) begin t++; @(negedge clk_100); end
        if (!led_sdi[ch]) begin
            check($sformatf("ch%0d_start", ch), 0, 1);
            return;
        end
        for (int b = 15; b >= 0; b--) begin
            hi = 0; lo = 0;
            while (led_sdi[ch] && hi < 300) begin hi++; other += int'(led_sdi[ch^1]); @(negedge clk_100); end
            while (!led_sdi[ch] && lo < 300) begin lo++; other += int'(led_sdi[ch^1]); @(negedge clk_100); end
            check($sformatf("ch%0d_b%0d_high", ch, b), hi, d[b] ? T1H : T0H);
            if (b > 0) check($sformatf("ch%0d_b%0d_period", ch, b), hi + lo, TBIT);
            else       check($sformatf("ch%0d_tail_low", ch), lo, 300);
        end
        check($sformatf("ch%0d_other_quiet", ch), other, 0);
    endtask

    task automatic send(int ch, logic [15:0] d);
        fork
            measure(ch, d);
            gpmc_write(16'h1000 | 16'(ch), d);
        join
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] v, d, a;
        int ch, t, hits;
        cycles(10);
        check("rst_led", led, 0);
        check("rst_sdi", led_sdi, 0);
        reset = 1'b0;
        cycles(5);
        gpmc_write(16'h0001, 16'h0005);
        led_exp = 4'h5;
        check("led_write", led, led_exp);
`ifdef GPMC_READBACK_EN
        gpmc_read(16'h0000, v); check("rd_id", v, ID);
        gpmc_read(16'h0001, v); check("rd_led", v, 16'h0005);
`else
        gpmc_read(16'h0000, v); check("bus_not_driven", v === ID, 0);
`endif
        send(0, 16'hABCD);
        fork
            measure(0, 16'hABCD);
            repeat (4) gpmc_write(16'h1000, 16'hABCD);
        join
`ifdef GPMC_READBACK_EN
        gpmc_read(16'h0002, v); check("status_ovf0", v, 16'h0004);
        gpmc_write(16'h0002, 16'h0004);
        gpmc_read(16'h0002, v); check("status_clr", v, 16'h0000);
`endif
        for (int i = 0; i < 6; i++) begin
            d = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       a = 16'h0000;
                1:       a = 16'h0003 + 16'($urandom_range(0, 16'h0FFC));
                default: a = 16'h0001;
            endcase
            gpmc_write(a, d);
            if (a == 16'h0001) led_exp = d[3:0];
            check($sformatf("led_rand%0d", i), led, led_exp);
        end
        for (int i = 0; i < 4; i++) begin
            ch = int'($urandom_range(0, 1));
            send(ch, 16'($urandom));
        end
        d = 16'($urandom) | 16'h8000;
        fork
            gpmc_write(16'h1001, d);
            begin
                t = 0;
                while (!led_sdi[1] && t < 300) begin t++; @(negedge clk_100); end
                check("mid_start", led_sdi[1], 1);
                cycles(1000);
                reset = 1'b1;
                @(negedge clk_100);
                check("mid_rst_sdi", led_sdi, 0);
                check("mid_rst_led", led, 0);
                led_exp = '0;
                cycles(3);
                reset = 1'b0;
            end
        join
        hits = 0;
        repeat (300) begin @(negedge clk_100); hits += int'(led_sdi[1]); end
        check("mid_rst_quiet", hits, 0);
`ifdef GPMC_READBACK_EN
        gpmc_read(16'h0002, v); check("mid_rst_status", v, 16'h0000);
`endif
        send(1, 16'($urandom));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
